// File: rtl/serial_subtractor_2b_pkg.sv
// Shared definitions for the digit-serial 2-bit-per-cycle subtractor.
package serial_subtractor_2b_pkg;

    // Bits consumed per clock.
    localparam int DIGIT_W = 2;

    // Two-state controller: waiting for a request, or stepping digits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of a counter that indexes ndig digits; never narrower than one bit.
    function automatic int cnt_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/serial_subtractor_2b_sub2_digit.sv
// Combinational 2-bit digit subtractor: d = a - b - bin (mod 4), with borrow-out.
module sub2_digit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       bin,
    output logic [1:0] d,
    output logic       bout
);

    // a - b - bin lies in -4..3, so the sign of a 3-bit result is the borrow.
    logic [2:0] full;

    assign full = {1'b0, a} - {1'b0, b} - {2'b00, bin};
    assign d    = full[1:0];
    assign bout = full[2];

endmodule

// File: rtl/serial_subtractor_2b.sv
// Digit-serial subtractor: Diff = A - B - Bin, two bits per clock, LSB digit first.
// WIDTH must be even and at least 2.
module serial_subtractor_2b
    import serial_subtractor_2b_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = cnt_width(NDIG);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_nxt;
    logic               borrow;
    logic [DIGIT_W-1:0] dig;
    logic               dig_bout;
    logic               last;

    // The single digit cell always looks at the low digit of the operand shifters.
    sub2_digit u_digit (
        .a    (a_sh[DIGIT_W-1:0]),
        .b    (b_sh[DIGIT_W-1:0]),
        .bin  (borrow),
        .d    (dig),
        .bout (dig_bout)
    );

    assign last = (cnt == CNT_W'(NDIG - 1));
    assign busy = (state == ST_RUN);

    // New digit enters at the MSB end so the first digit lands at bit 0 after NDIG shifts.
    assign res_nxt = (res >> DIGIT_W) | (WIDTH'(dig) << (WIDTH - DIGIT_W));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept only in IDLE, return to IDLE after the last digit.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, digit stepping, borrow ripple and result publication.
    // NOTE: every datapath register is reset so an aborted run never exposes partial state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        res    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT_W;
                    b_sh   <= b_sh >> DIGIT_W;
                    borrow <= dig_bout;
                    res    <= res_nxt;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        Diff <= res_nxt;
                        Bout <= dig_bout;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_2b.sv
// Directed bench for serial_subtractor_2b at WIDTH=8 and WIDTH=2.
module tb_serial_subtractor_2b;

    logic clk = 1'b0;
    logic rst_n;

    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;

    logic       start2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    serial_subtractor_2b #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .Diff  (diff8),
        .Bout  (bout8)
    );

    serial_subtractor_2b #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .A     (a2),
        .B     (b2),
        .Bin   (bin2),
        .busy  (busy2),
        .done  (done2),
        .Diff  (diff2),
        .Bout  (bout2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Wait at negedges until done8 rises; lat returns the number of edges waited.
    task automatic wait_done8(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done8 && lat < 20) begin
            if (busy8) busy_n++;
            @(negedge clk);
            lat++;
        end
        check("done8_seen", 32'(done8), 32'd1);
    endtask

    // One full WIDTH=8 operation with latency, busy and result checks.
    task automatic op8(input vec_t v, input string nm);
        int lat;
        int busy_n;
        @(negedge clk);
        a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~v.a; b8 = ~v.b; bin8 = ~v.bin;
        wait_done8(lat, busy_n);
        check({nm, "_latency"}, 32'(lat), 32'd4);
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'd4);
        check({nm, "_busy_at_done"}, 32'(busy8), 32'd0);
        check({nm, "_diff"}, 32'(diff8), 32'(v.diff));
        check({nm, "_bout"}, 32'(bout8), 32'(v.bout));
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        int lat;
        int busy_n;
        vec_t bb[3];

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0};
        vecs[7] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};

        bb[0] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
        bb[1] = '{8'hC3, 8'h41, 1'b1, 8'h81, 1'b0};
        bb[2] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        #1;
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        check("reset_diff", 32'(diff8), 32'd0);
        check("reset_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven WIDTH=8 vectors.
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i], $sformatf("vec%0d", i));
        end

        // Second start during RUN must be ignored; Diff holds until completion.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        check("ign_diff_hold", 32'(diff8), 32'h02);
        @(negedge clk);
        start8 = 1'b0;
        check("ign_busy", 32'(busy8), 32'd1);
        check("ign_diff_hold2", 32'(diff8), 32'h02);
        wait_done8(lat, busy_n);
        check("ign_diff", 32'(diff8), 32'h22);
        check("ign_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        check("ign_no_restart", 32'(busy8), 32'd0);

        // Start held high: each done-cycle presents the next operands.
        @(negedge clk);
        a8 = bb[0].a; b8 = bb[0].b; bin8 = bb[0].bin; start8 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wait_done8(lat, busy_n);
            check($sformatf("b2b%0d_diff", i), 32'(diff8), 32'(bb[i].diff));
            check($sformatf("b2b%0d_bout", i), 32'(bout8), 32'(bb[i].bout));
            if (i < 2) begin
                a8 = bb[i+1].a; b8 = bb[i+1].b; bin8 = bb[i+1].bin;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            check($sformatf("b2b%0d_done_pulse", i), 32'(done8), 32'd0);
        end
        @(negedge clk);

        // Asynchronous reset in the middle of a run clears outputs before any edge.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        check("arst_diff", 32'(diff8), 32'd0);
        check("arst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(vecs[7], "post_rst");

        // WIDTH=2 exhaustive: done follows the accept edge by one edge.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] idx;
            int t;
            idx = 5'(i);
            @(negedge clk);
            a2 = idx[4:3]; b2 = idx[2:1]; bin2 = idx[0]; start2 = 1'b1;
            t = int'(idx[4:3]) - int'(idx[2:1]) - int'(idx[0]);
            @(negedge clk);
            start2 = 1'b0;
            check($sformatf("w2_%0d_busy", i), 32'(busy2), 32'd1);
            @(negedge clk);
            check($sformatf("w2_%0d_done", i), 32'(done2), 32'd1);
            check($sformatf("w2_%0d_res", i), 32'({bout2, diff2}),
                  32'({(t < 0) ? 1'b1 : 1'b0, 2'(t & 3)}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
